butterfly_pipe: RTL and testbench

Pipelined, parametrised radix-2 DIT butterfly: X' = (X + W·Y)/s, Y' = (X − W·Y)/s, with s = 1 or 2 selected per sample. Replaces the combinational butterfly in FFT stage datapaths where timing closure and backpressure are needed. Adds a three-stage registered pipeline, valid/ready flow control, round-half-up on every right shift, and output saturation.

---
 rtl/fft_pkg.sv | 43 ++++
 rtl/sat_round.sv | 33 +++
 rtl/butterfly_pipe.sv | 204 ++++++++++++++++++++
 tb/tb_butterfly_pipe.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared width helpers and fixed-point rounding/saturation functions for FFT datapaths.
package fft_pkg;

  function automatic int unsigned prod_w(input int unsigned nbd, input int unsigned nbt);
    return nbd + nbt;
  endfunction

  function automatic int unsigned tw_term_w(input int unsigned nbd);
    return nbd + 2;
  endfunction

  function automatic int unsigned sum_w(input int unsigned nbd);
    return nbd + 3;
  endfunction

  // Arithmetic right shift with round-half-up (ties toward +inf).
  function automatic longint round_shift(input longint v, input int unsigned sh);
    longint res;
    if (sh == 0) begin
      res = v;
    end else begin
      res = (v + (longint'(1) <<< (sh - 1))) >>> sh;
    end
    return res;
  endfunction

  function automatic longint sat_n(input longint v, input int unsigned n);
    longint max_v;
    longint min_v;
    longint res;
    max_v = (longint'(1) <<< (n - 1)) - 1;
    min_v = -max_v - 1;
    if (v > max_v) begin
      res = max_v;
    end else if (v < min_v) begin
      res = min_v;
    end else begin
      res = v;
    end
    return res;
  endfunction

endpackage

// File: rtl/sat_round.sv
// Combinational round-half-up right shift followed by optional saturation to OW bits.
module sat_round
  import fft_pkg::*;
#(
  parameter int unsigned IW     = 11,
  parameter int unsigned OW     = 8,
  parameter int unsigned SHIFT  = 1,
  parameter bit          SAT_EN = 1'b1
) (
  input  logic [IW-1:0] i_val,
  input  logic          i_shift,
  output logic [OW-1:0] o_val,
  output logic          o_clip
);

  longint w_in;
  longint w_rnd;
  longint w_sat;

  always_comb begin
    w_in  = longint'($signed(i_val));
    w_rnd = i_shift ? round_shift(w_in, SHIFT) : w_in;
    w_sat = SAT_EN ? sat_n(w_rnd, OW) : w_rnd;
  end

  // Without saturation the caller guarantees the result already fits in OW bits.
  assign o_val  = w_sat[OW-1:0];
  assign o_clip = SAT_EN && (w_sat != w_rnd);

  logic [63-OW:0] w_unused_hi;
  assign w_unused_hi = w_sat[63:OW];

endmodule

// File: rtl/butterfly_pipe.sv
// Three-stage pipelined radix-2 DIT butterfly with valid/ready, rounding and saturation.
// Optional overflow counter enabled by defining BUTTERFLY_PIPE_OVF_EN.
module butterfly_pipe
  import fft_pkg::*;
#(
  parameter int unsigned NBD   = 8,
  parameter int unsigned NBT   = 8,
  parameter int unsigned OVF_W = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic           i_scale,
  input  logic [NBD-1:0] i_x_real,
  input  logic [NBD-1:0] i_x_imag,
  input  logic [NBD-1:0] i_y_real,
  input  logic [NBD-1:0] i_y_imag,
  input  logic [NBT-1:0] i_twiddle_real,
  input  logic [NBT-1:0] i_twiddle_imag,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [NBD-1:0] o_x_real,
  output logic [NBD-1:0] o_x_imag,
  output logic [NBD-1:0] o_y_real,
  output logic [NBD-1:0] o_y_imag,
  output logic           o_sat
`ifdef BUTTERFLY_PIPE_OVF_EN
  ,
  input  logic             i_ovf_clr,
  output logic [OVF_W-1:0] o_ovf_cnt
`endif
);

  localparam int unsigned PW = prod_w(NBD, NBT);
  localparam int unsigned TW = tw_term_w(NBD);
  localparam int unsigned SW = sum_w(NBD);
  localparam int unsigned AW = PW + 1;

  logic r3_valid;
  logic w_en;

  assign w_en    = !r3_valid || i_ready;
  assign o_ready = w_en;

  // Stage 1: products
  logic signed [PW-1:0] w_p_rr, w_p_ii, w_p_ri, w_p_ir;

  assign w_p_rr = PW'($signed(i_y_real)) * PW'($signed(i_twiddle_real));
  assign w_p_ii = PW'($signed(i_y_imag)) * PW'($signed(i_twiddle_imag));
  assign w_p_ri = PW'($signed(i_y_real)) * PW'($signed(i_twiddle_imag));
  assign w_p_ir = PW'($signed(i_y_imag)) * PW'($signed(i_twiddle_real));

  logic                  r1_valid;
  logic                  r1_scale;
  logic signed [NBD-1:0] r1_xr, r1_xi;
  logic signed [PW-1:0]  r1_prr, r1_pii, r1_pri, r1_pir;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r1_valid <= 1'b0;
      r1_scale <= 1'b0;
      r1_xr    <= '0;
      r1_xi    <= '0;
      r1_prr   <= '0;
      r1_pii   <= '0;
      r1_pri   <= '0;
      r1_pir   <= '0;
    end else if (w_en) begin
      r1_valid <= i_valid;
      r1_scale <= i_scale;
      r1_xr    <= i_x_real;
      r1_xi    <= i_x_imag;
      r1_prr   <= w_p_rr;
      r1_pii   <= w_p_ii;
      r1_pri   <= w_p_ri;
      r1_pir   <= w_p_ir;
    end
  end

  // Stage 2: twiddle term T = W*Y, rounded back to data scale
  logic signed [AW-1:0] w_acc_r, w_acc_i;
  logic [TW-1:0]        w_tr, w_ti;
  logic                 w_unused_tclip_r, w_unused_tclip_i;

  assign w_acc_r = AW'(r1_prr) - AW'(r1_pii);
  assign w_acc_i = AW'(r1_pri) + AW'(r1_pir);

  sat_round #(
    .IW    (AW),
    .OW    (TW),
    .SHIFT (NBT - 1),
    .SAT_EN(1'b0)
  ) u_tw_r (
    .i_val  (w_acc_r),
    .i_shift(1'b1),
    .o_val  (w_tr),
    .o_clip (w_unused_tclip_r)
  );

  sat_round #(
    .IW    (AW),
    .OW    (TW),
    .SHIFT (NBT - 1),
    .SAT_EN(1'b0)
  ) u_tw_i (
    .i_val  (w_acc_i),
    .i_shift(1'b1),
    .o_val  (w_ti),
    .o_clip (w_unused_tclip_i)
  );

  logic                  r2_valid;
  logic                  r2_scale;
  logic signed [NBD-1:0] r2_xr, r2_xi;
  logic signed [TW-1:0]  r2_tr, r2_ti;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r2_valid <= 1'b0;
      r2_scale <= 1'b0;
      r2_xr    <= '0;
      r2_xi    <= '0;
      r2_tr    <= '0;
      r2_ti    <= '0;
    end else if (w_en) begin
      r2_valid <= r1_valid;
      r2_scale <= r1_scale;
      r2_xr    <= r1_xr;
      r2_xi    <= r1_xi;
      r2_tr    <= w_tr;
      r2_ti    <= w_ti;
    end
  end

  // Stage 3: X +/- T, optional halving, saturation
  logic signed [SW-1:0] w_sum_r, w_sum_i, w_dif_r, w_dif_i;
  logic [NBD-1:0]       w_xr, w_xi, w_yr, w_yi;
  logic [3:0]           w_clip;

  assign w_sum_r = SW'(r2_xr) + SW'(r2_tr);
  assign w_sum_i = SW'(r2_xi) + SW'(r2_ti);
  assign w_dif_r = SW'(r2_xr) - SW'(r2_tr);
  assign w_dif_i = SW'(r2_xi) - SW'(r2_ti);

  sat_round #(.IW(SW), .OW(NBD), .SHIFT(1), .SAT_EN(1'b1)) u_sr_xr (
    .i_val(w_sum_r), .i_shift(r2_scale), .o_val(w_xr), .o_clip(w_clip[0])
  );
  sat_round #(.IW(SW), .OW(NBD), .SHIFT(1), .SAT_EN(1'b1)) u_sr_xi (
    .i_val(w_sum_i), .i_shift(r2_scale), .o_val(w_xi), .o_clip(w_clip[1])
  );
  sat_round #(.IW(SW), .OW(NBD), .SHIFT(1), .SAT_EN(1'b1)) u_sr_yr (
    .i_val(w_dif_r), .i_shift(r2_scale), .o_val(w_yr), .o_clip(w_clip[2])
  );
  sat_round #(.IW(SW), .OW(NBD), .SHIFT(1), .SAT_EN(1'b1)) u_sr_yi (
    .i_val(w_dif_i), .i_shift(r2_scale), .o_val(w_yi), .o_clip(w_clip[3])
  );

  logic [NBD-1:0] r3_xr, r3_xi, r3_yr, r3_yi;
  logic           r3_sat;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r3_valid <= 1'b0;
      r3_sat   <= 1'b0;
      r3_xr    <= '0;
      r3_xi    <= '0;
      r3_yr    <= '0;
      r3_yi    <= '0;
    end else if (w_en) begin
      r3_valid <= r2_valid;
      r3_sat   <= |w_clip;
      r3_xr    <= w_xr;
      r3_xi    <= w_xi;
      r3_yr    <= w_yr;
      r3_yi    <= w_yi;
    end
  end

  assign o_valid  = r3_valid;
  assign o_sat    = r3_sat;
  assign o_x_real = r3_xr;
  assign o_x_imag = r3_xi;
  assign o_y_real = r3_yr;
  assign o_y_imag = r3_yi;

`ifdef BUTTERFLY_PIPE_OVF_EN
  logic [OVF_W-1:0] r_ovf_cnt;

  // Clear wins over increment; count sticks at all-ones.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_ovf_clr) begin
      r_ovf_cnt <= '0;
    end else if (r3_valid && i_ready && r3_sat && !(&r_ovf_cnt)) begin
      r_ovf_cnt <= r_ovf_cnt + 1'b1;
    end
  end

  assign o_ovf_cnt = r_ovf_cnt;
`else
  localparam int unsigned unused_ovf_w = OVF_W;
`endif

endmodule

// File: tb/tb_butterfly_pipe.sv
// Directed self-checking bench for butterfly_pipe (NBD=NBT=8).
module tb_butterfly_pipe;

  localparam int unsigned NBD   = 8;
  localparam int unsigned NBT   = 8;
  localparam int unsigned OVF_W = 16;

  logic           clk = 1'b0;
  logic           i_rst = 1'b1;
  logic           i_valid = 1'b0;
  logic           o_ready;
  logic           i_scale = 1'b0;
  logic [NBD-1:0] i_x_real = '0, i_x_imag = '0, i_y_real = '0, i_y_imag = '0;
  logic [NBT-1:0] i_twiddle_real = '0, i_twiddle_imag = '0;
  logic           o_valid;
  logic           i_ready = 1'b1;
  logic [NBD-1:0] o_x_real, o_x_imag, o_y_real, o_y_imag;
  logic           o_sat;
`ifdef BUTTERFLY_PIPE_OVF_EN
  logic             i_ovf_clr = 1'b0;
  logic [OVF_W-1:0] o_ovf_cnt;
`endif

  always #5 clk = ~clk;

  butterfly_pipe #(
    .NBD  (NBD),
    .NBT  (NBT),
    .OVF_W(OVF_W)
  ) u_dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_valid       (i_valid),
    .o_ready       (o_ready),
    .i_scale       (i_scale),
    .i_x_real      (i_x_real),
    .i_x_imag      (i_x_imag),
    .i_y_real      (i_y_real),
    .i_y_imag      (i_y_imag),
    .i_twiddle_real(i_twiddle_real),
    .i_twiddle_imag(i_twiddle_imag),
    .o_valid       (o_valid),
    .i_ready       (i_ready),
    .o_x_real      (o_x_real),
    .o_x_imag      (o_x_imag),
    .o_y_real      (o_y_real),
    .o_y_imag      (o_y_imag),
    .o_sat         (o_sat)
`ifdef BUTTERFLY_PIPE_OVF_EN
    ,
    .i_ovf_clr     (i_ovf_clr),
    .o_ovf_cnt     (o_ovf_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic signed [63:0] obs,
                          input logic signed [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sc, input int xr, input int xi, input int yr, input int yi,
                       input int wr, input int wi);
    i_valid        = 1'b1;
    i_scale        = sc[0];
    i_x_real       = NBD'(xr);
    i_x_imag       = NBD'(xi);
    i_y_real       = NBD'(yr);
    i_y_imag       = NBD'(yi);
    i_twiddle_real = NBT'(wr);
    i_twiddle_imag = NBT'(wi);
  endtask

  task automatic check_out(input string tag, input int exr, input int exi, input int eyr,
                           input int eyi, input int esat);
    check_eq({tag, "/xr"}, $signed(o_x_real), exr);
    check_eq({tag, "/xi"}, $signed(o_x_imag), exi);
    check_eq({tag, "/yr"}, $signed(o_y_real), eyr);
    check_eq({tag, "/yi"}, $signed(o_y_imag), eyi);
    check_eq({tag, "/sat"}, o_sat, esat);
  endtask

  // Single beat into an empty pipe; result must appear exactly three cycles later.
  task automatic run_vec(input string tag, input int sc, input int xr, input int xi,
                         input int yr, input int yi, input int wr, input int wi,
                         input int exr, input int exi, input int eyr, input int eyi,
                         input int esat);
    tick();
    i_ready = 1'b1;
    drive(sc, xr, xi, yr, yi, wr, wi);
    #1;
    check_eq({tag, "/rdy"}, o_ready, 1);
    for (int c = 1; c <= 3; c++) begin
      tick();
      i_valid = 1'b0;
      #1;
      check_eq($sformatf("%s/lat%0d", tag, c), o_valid, (c == 3) ? 1 : 0);
    end
    check_out(tag, exr, exi, eyr, eyi, esat);
  endtask

  logic [3:0] rdy_pat = 4'b1001;

  initial begin
    int in_k;
    int out_k;
    int k;
    bit stalled_prev;
    logic [NBD-1:0] hold_xr, hold_yr;

    repeat (3) tick();
    i_rst = 1'b0;
    #1;
    check_eq("rst/valid", o_valid, 0);
    check_eq("rst/sat", o_sat, 0);
    check_eq("rst/xr", o_x_real, 0);
    check_eq("rst/yi", o_y_imag, 0);
    check_eq("rst/ready", o_ready, 1);
`ifdef BUTTERFLY_PIPE_OVF_EN
    check_eq("rst/ovf", o_ovf_cnt, 0);
`endif

    run_vec("basic_s1", 1, 10, 0, 20, 0, 127, 0, 15, 0, -5, 0, 0);
    run_vec("basic_s0", 0, 10, 0, 20, 0, 127, 0, 30, 0, -10, 0, 0);
    run_vec("satur", 0, 100, 0, 100, 0, 127, 0, 127, 0, 1, 0, 1);
    tick();
    check_eq("satur/vdrop", o_valid, 0);
`ifdef BUTTERFLY_PIPE_OVF_EN
    check_eq("ovf/one", o_ovf_cnt, 1);
`endif
    run_vec("ext_s0", 0, 0, 0, -128, 0, -128, 0, 127, 0, -128, 0, 1);
    run_vec("ext_s1", 1, 0, 0, -128, 0, -128, 0, 64, 0, -64, 0, 0);
    run_vec("cmul", 0, 0, 0, 64, 32, 0, 127, -32, 64, 32, -64, 0);
`ifdef BUTTERFLY_PIPE_OVF_EN
    tick();
    check_eq("ovf/two", o_ovf_cnt, 2);
    i_ovf_clr = 1'b1;
    tick();
    i_ovf_clr = 1'b0;
    #1;
    check_eq("ovf/clr", o_ovf_cnt, 0);
`endif

    // Backpressure: 8 beats, i_ready pattern 1,0,0,1 repeating.
    in_k = 0;
    out_k = 0;
    stalled_prev = 1'b0;
    hold_xr = '0;
    hold_yr = '0;
    for (int cyc = 0; cyc < 200 && out_k < 8; cyc++) begin
      tick();
      i_ready = rdy_pat[cyc % 4];
      if (in_k < 8) drive(0, 10 * (in_k + 1), -(in_k + 1), in_k + 1, 0, 127, 0);
      else i_valid = 1'b0;
      #1;
      check_eq("bp/ordy", o_ready, (o_valid && !i_ready) ? 0 : 1);
      if (stalled_prev) begin
        check_eq("bp/hold_v", o_valid, 1);
        check_eq("bp/hold_xr", o_x_real, hold_xr);
        check_eq("bp/hold_yr", o_y_real, hold_yr);
      end
      if (o_valid) begin
        k = out_k + 1;
        check_out($sformatf("bp/beat%0d", k), 11 * k, -k, 9 * k, -k, 0);
      end
      stalled_prev = o_valid && !i_ready;
      hold_xr = o_x_real;
      hold_yr = o_y_real;
      if (o_valid && i_ready) out_k++;
      if (i_valid && o_ready) in_k++;
    end
    check_eq("bp/count", out_k, 8);
    i_ready = 1'b1;
    i_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_eq("bp/nodup", o_valid, 0);
    end

    // Reset while two beats are in flight.
    tick();
    drive(0, 5, 0, 0, 0, 0, 0);
    tick();
    drive(0, 6, 0, 0, 0, 0, 0);
    tick();
    i_valid = 1'b0;
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    #1;
    check_eq("mrst/xr", o_x_real, 0);
    for (int c = 0; c < 4; c++) begin
      check_eq($sformatf("mrst/v%0d", c), o_valid, 0);
      tick();
    end
    run_vec("mrst/new", 1, 10, 0, 20, 0, 127, 0, 15, 0, -5, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
